// File: rtl/tinker_fetch_queue.sv
// Tinker fetch stage: owns the PC, issues one imem read per cycle while credit remains,
// and queues {pc, instruction} pairs for decode. A redirect flushes queued and in-flight work.
module tinker_fetch_queue #(
    parameter logic [63:0] RESET_PC = 64'h2000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        IF_DE_valid,
    output logic [31:0] IF_DE_instruction,
    output logic [63:0] IF_DE_pc,
    input  logic        DE_ready
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [63:0]   pc_q, pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          inflight_q, inflight_d;
    logic [63:0]   inflight_pc_q, inflight_pc_d;

    logic [31:0]   inst_mem [DEPTH];
    logic [63:0]   pc_mem   [DEPTH];

    logic          issue;
    logic          push;
    logic          pop;
    logic [PW+1:0] occupancy;

    // Credit covers both buffered entries and the read still in flight.
    assign occupancy = {1'b0, count_q} + {{(PW + 1){1'b0}}, inflight_q};
    assign issue     = reset && !redirect_valid && (occupancy < (PW + 2)'(DEPTH));
    assign push      = inflight_q && !redirect_valid;
    assign pop       = IF_DE_valid && DE_ready && !redirect_valid;

    assign imem_req          = issue;
    assign imem_addr         = pc_q;
    assign IF_DE_valid       = (count_q != '0);
    assign IF_DE_instruction = IF_DE_valid ? inst_mem[rd_ptr_q] : 32'h0;
    assign IF_DE_pc          = IF_DE_valid ? pc_mem[rd_ptr_q] : 64'h0;

    always_comb begin
        pc_d          = pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (issue) begin
                pc_d          = pc_q + 64'd4;
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + (PW + 1)'(1);
                2'b01:   count_d = count_q - (PW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 64'h0;
        end else begin
            pc_q          <= pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]   <= inflight_pc_q;
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (!reset)
        push |-> (count_q < (PW + 1)'(DEPTH)));

endmodule

// File: tb/tb_tinker_fetch_queue.sv
// Self-checking bench for tinker_fetch_queue: a queue-based reference model predicts
// every output each cycle; directed scenarios add fixed-value checks.
module tb_tinker_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h2000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        IF_DE_valid;
    logic [31:0] IF_DE_instruction;
    logic [63:0] IF_DE_pc;
    logic        DE_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [63:0] m_pc;
    logic [63:0] m_ipc;
    logic        m_inflight;
    logic [63:0] m_q[$];

    logic        e_req, e_valid;
    logic [63:0] e_addr, e_hpc;
    logic [31:0] e_hinst;
    logic [161:0] got, want;

    tinker_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .IF_DE_valid       (IF_DE_valid),
        .IF_DE_instruction (IF_DE_instruction),
        .IF_DE_pc          (IF_DE_pc),
        .DE_ready          (DE_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0BAD_F00D;
    endfunction

    // Registered-read instruction memory
    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    function automatic void model_reset();
        m_pc = RESET_PC;
        m_ipc = 64'h0;
        m_inflight = 1'b0;
        m_q.delete();
    endfunction

    function automatic void model_eval();
        e_req   = !redirect_valid && ((m_q.size() + int'(m_inflight)) < DEPTH);
        e_addr  = m_pc;
        e_valid = (m_q.size() != 0);
        e_hpc   = e_valid ? m_q[0] : 64'h0;
        e_hinst = e_valid ? mem_word(m_q[0]) : 32'h0;
    endfunction

    function automatic void model_commit();
        bit iss;
        if (redirect_valid) begin
            m_q.delete();
            m_inflight = 1'b0;
            m_pc = redirect_pc;
        end else begin
            iss = (m_q.size() + int'(m_inflight)) < DEPTH;
            if (m_q.size() != 0 && DE_ready) void'(m_q.pop_front());
            if (m_inflight) m_q.push_back(m_ipc);
            if (iss) begin
                m_ipc = m_pc;
                m_pc = m_pc + 64'd4;
                m_inflight = 1'b1;
            end else begin
                m_inflight = 1'b0;
            end
        end
    endfunction

    task automatic drive(input logic redir, input logic [63:0] rpc, input logic rdy);
        @(negedge clk);
        redirect_valid = redir;
        redirect_pc = rpc;
        DE_ready = rdy;
        #1;
        model_eval();
        got  = {imem_req, imem_req ? imem_addr : 64'h0, IF_DE_valid, IF_DE_pc, IF_DE_instruction};
        want = {e_req, e_req ? e_addr : 64'h0, e_valid, e_hpc, e_hinst};
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
    endtask

    // Called right after advance(); holds reset for two edges and releases just after an edge.
    task automatic apply_reset();
        #2 reset = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        DE_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++; $display("FAIL reset_req got=%b want=0", imem_req);
        end
        checks++;
        if (IF_DE_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b want=0", IF_DE_valid);
        end
        checks++;
        if (IF_DE_instruction !== 32'h0 || IF_DE_pc !== 64'h0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h want=0/0", IF_DE_instruction, IF_DE_pc);
        end
        #1 reset = 1'b1;
        model_reset();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 64'h0, 1'b1);
            checks++;
            if (got !== want) begin
                failures++; $display("FAIL stream cyc=%0d got=%h want=%h", i, got, want);
            end
            if (i == 0) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 64'h2000) begin
                    failures++;
                    $display("FAIL stream_first_req got=%b/%h want=1/2000", imem_req, imem_addr);
                end
            end
            if (i == 1) begin
                checks++;
                if (IF_DE_valid !== 1'b0) begin
                    failures++; $display("FAIL stream_early_valid got=%b want=0", IF_DE_valid);
                end
            end
            if (i >= 2 && i <= 5) begin
                checks++;
                if (IF_DE_valid !== 1'b1 || IF_DE_pc !== 64'h2000 + 64'(4 * (i - 2))
                    || IF_DE_instruction !== mem_word(64'h2000 + 64'(4 * (i - 2)))) begin
                    failures++;
                    $display("FAIL stream_head cyc=%0d got=%b/%h/%h", i, IF_DE_valid, IF_DE_pc,
                             IF_DE_instruction);
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        int nreq = 0;
        logic seen = 1'b0;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 64'h0, 1'b0);
            if (imem_req === 1'b1) nreq++;
            checks++;
            if (got !== want) begin
                failures++; $display("FAIL bp_fill cyc=%0d got=%h want=%h", i, got, want);
            end
            advance();
        end
        checks++;
        if (nreq != 4) begin
            failures++; $display("FAIL bp_req_count got=%0d want=4", nreq);
        end
        drive(1'b0, 64'h0, 1'b0);
        checks++;
        if (IF_DE_valid !== 1'b1 || IF_DE_pc !== 64'h2000 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold got=%b/%h/%b want=1/2000/0", IF_DE_valid, IF_DE_pc, imem_req);
        end
        advance();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 64'h0, 1'b1);
            checks++;
            if (got !== want) begin
                failures++; $display("FAIL bp_drain cyc=%0d got=%h want=%h", i, got, want);
            end
            if (!seen && imem_req === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (imem_addr !== 64'h2010) begin
                    failures++; $display("FAIL bp_resume got=%h want=2010", imem_addr);
                end
            end
            advance();
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            drive(i == 3, 64'h3000, 1'b0);
            checks++;
            if (got !== want) begin
                failures++; $display("FAIL redir cyc=%0d got=%h want=%h", i, got, want);
            end
            if (i == 3) begin
                checks++;
                if (imem_req !== 1'b0) begin
                    failures++; $display("FAIL redir_noissue got=%b want=0", imem_req);
                end
            end
            if (i == 4) begin
                checks++;
                if (IF_DE_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h3000) begin
                    failures++;
                    $display("FAIL redir_after got=%b/%b/%h want=0/1/3000", IF_DE_valid,
                             imem_req, imem_addr);
                end
            end
            if (i == 6) begin
                checks++;
                if (IF_DE_valid !== 1'b1 || IF_DE_pc !== 64'h3000) begin
                    failures++;
                    $display("FAIL redir_first got=%b/%h want=1/3000", IF_DE_valid, IF_DE_pc);
                end
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            drive(i == 3 || i == 4, (i == 3) ? 64'h4000 : 64'h5000, 1'b1);
            checks++;
            if (got !== want) begin
                failures++; $display("FAIL b2b cyc=%0d got=%h want=%h", i, got, want);
            end
            if (i == 3) begin
                checks++;
                if (IF_DE_valid !== 1'b1) begin
                    failures++; $display("FAIL b2b_head got=%b want=1", IF_DE_valid);
                end
            end
            if (i == 5) begin
                checks++;
                if (IF_DE_valid !== 1'b0 || imem_addr !== 64'h5000) begin
                    failures++;
                    $display("FAIL b2b_flush got=%b/%h want=0/5000", IF_DE_valid, imem_addr);
                end
            end
            if (i == 7) begin
                checks++;
                if (IF_DE_pc !== 64'h5000) begin
                    failures++; $display("FAIL b2b_first got=%h want=5000", IF_DE_pc);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic        redir;
        logic [63:0] rpc;
        for (int i = 0; i < 1000; i++) begin
            redir = ($urandom_range(0, 39) == 0);
            rpc = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) rpc = {32'h0, 16'h0, rpc[15:0]};
            drive(redir, rpc, ($urandom_range(0, 2) != 0));
            checks++;
            if (got !== want) begin
                failures++; $display("FAIL random cyc=%0d got=%h want=%h", i, got, want);
            end
            advance();
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 64'h0, 1'b1);
            advance();
        end
        drive(1'b0, 64'h0, 1'b1);
        checks++;
        if (imem_req !== 1'b1) begin
            failures++; $display("FAIL mid_pre_req got=%b want=1", imem_req);
        end
        advance();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || IF_DE_valid !== 1'b0 || IF_DE_instruction !== 32'h0
            || IF_DE_pc !== 64'h0) begin
            failures++;
            $display("FAIL mid_async got=%b/%b/%h/%h want=0/0/0/0", imem_req, IF_DE_valid,
                     IF_DE_instruction, IF_DE_pc);
        end
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 64'h0, 1'b1);
            checks++;
            if (got !== want) begin
                failures++; $display("FAIL mid_resume cyc=%0d got=%h want=%h", i, got, want);
            end
            if (i == 0) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 64'h2000 || IF_DE_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL mid_first got=%b/%h/%b want=1/2000/0", imem_req, imem_addr,
                             IF_DE_valid);
                end
            end
            advance();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
